store_buffer: RTL

Committed-store buffer between the load/store unit and the TCM data port. Accepts committed stores in program order, holds them in a circular FIFO, and drains one store per cycle into the TCM write port. Services loads through the TCM read port and merges byte-accurate forwarded data from pending stores, so loads observe every older store even before it has drained.

---
 rtl/store_buffer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer
//   Committed-store buffer between the load/store unit and the TCM data port.
//   Stores arrive in program order. They are held in a circular FIFO and drain
//   one per cycle into the TCM write port. Loads are sent straight to the TCM
//   read port. Pending stores are merged into the load result byte by byte, so
//   a load observes every older store even before that store has drained.
//
//   Build option: define STBUF_FORWARD_EN to build the store-to-load forwarding
//   comparators. Without it, a load is held off until the buffer is empty and no
//   store is being pushed, and the load returns TCM data directly.
//
// Ports
//   clk, rst                     clock; asynchronous active-low reset
//   lsu_stbuf_push_*             committed store {valid, addr, size, data}
//   stbuf_lsu_push_ready         a free entry exists
//   stbuf_lsu_empty              no pending stores
//   lsu_stbuf_load_*             load request {valid, addr, size}
//   stbuf_lsu_load_ready         load accepted this cycle
//   stbuf_lsu_load_data_valid    load result valid (one cycle after accept)
//   stbuf_lsu_load_data          little-endian load bytes, zero above size
//   stbuf_tcm_read_*, _rd        TCM read request
//   tcm_stbuf_read_data          TCM read data, one cycle after request
//   stbuf_tcm_write_*, _wr       TCM write request (always accepted)
module store_buffer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_stbuf_push_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_stbuf_push_addr,
  input  logic [1:0]            lsu_stbuf_push_size,
  input  logic [DATA_WIDTH-1:0] lsu_stbuf_push_data,
  output logic                  stbuf_lsu_push_ready,
  output logic                  stbuf_lsu_empty,
  input  logic                  lsu_stbuf_load_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_stbuf_load_addr,
  input  logic [1:0]            lsu_stbuf_load_size,
  output logic                  stbuf_lsu_load_ready,
  output logic                  stbuf_lsu_load_data_valid,
  output logic [DATA_WIDTH-1:0] stbuf_lsu_load_data,
  output logic [ADDR_WIDTH-1:0] stbuf_tcm_read_addr,
  output logic [1:0]            stbuf_tcm_read_size,
  output logic                  stbuf_tcm_rd,
  input  logic [DATA_WIDTH-1:0] tcm_stbuf_read_data,
  output logic [ADDR_WIDTH-1:0] stbuf_tcm_write_addr,
  output logic [1:0]            stbuf_tcm_write_size,
  output logic [DATA_WIDTH-1:0] stbuf_tcm_write_data,
  output logic                  stbuf_tcm_wr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [1:0]            size_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;

  logic push_fire;
  logic drain;
  logic load_fire;

  logic                  ld_valid_q;
  logic [1:0]            ld_size_q;
  logic [NB-1:0]         fwd_mask_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  function automatic int size_bytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  // ---------------------------------------------------------------- FIFO
  // The full check uses the registered count only. A drain in the same cycle
  // does not open a slot for the push.
  assign stbuf_lsu_push_ready = (count_q < DEPTH_C);
  assign stbuf_lsu_empty      = (count_q == '0);
  assign push_fire            = lsu_stbuf_push_valid & stbuf_lsu_push_ready;
  assign drain                = ~stbuf_lsu_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_fire) tail_q <= tail_q + PTR_W'(1);
      if (drain)     head_q <= head_q + PTR_W'(1);
      if (push_fire && !drain)      count_q <= count_q + CNT_W'(1);
      else if (!push_fire && drain) count_q <= count_q - CNT_W'(1);
    end
  end

  // Entry payload needs no reset; only entries inside the count are ever used.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      addr_q[tail_q] <= lsu_stbuf_push_addr;
      size_q[tail_q] <= lsu_stbuf_push_size;
      data_q[tail_q] <= lsu_stbuf_push_data;
    end
  end

  // The TCM always accepts a write, so the head is presented whenever one exists.
  assign stbuf_tcm_wr         = drain;
  assign stbuf_tcm_write_addr = drain ? addr_q[head_q] : '0;
  assign stbuf_tcm_write_size = drain ? size_q[head_q] : '0;
  assign stbuf_tcm_write_data = drain ? data_q[head_q] : '0;

  // ---------------------------------------------------------------- loads
`ifdef STBUF_FORWARD_EN
  assign stbuf_lsu_load_ready = 1'b1;
`else
  assign stbuf_lsu_load_ready = stbuf_lsu_empty & ~lsu_stbuf_push_valid;
`endif

  assign load_fire           = lsu_stbuf_load_valid & stbuf_lsu_load_ready;
  assign stbuf_tcm_rd        = load_fire;
  assign stbuf_tcm_read_addr = lsu_stbuf_load_addr;
  assign stbuf_tcm_read_size = lsu_stbuf_load_size;

`ifdef STBUF_FORWARD_EN
  logic [NB-1:0]         fwd_mask_d;
  logic [DATA_WIDTH-1:0] fwd_data_d;
  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [PTR_W-1:0]      scan_idx;

  // Entries are scanned oldest to youngest, and the same-cycle push is scanned
  // last. Each later match overwrites an earlier one, so the youngest store wins.
  // The head entry is included because its TCM write lands at the same edge as
  // the TCM read, and the read returns the old contents.
  always_comb begin
    fwd_mask_d = '0;
    fwd_data_d = '0;
    byte_addr  = '0;
    scan_idx   = '0;
    for (int k = 0; k < NB; k++) begin
      byte_addr = lsu_stbuf_load_addr + ADDR_WIDTH'(k);
      if (k < size_bytes(lsu_stbuf_load_size)) begin
        for (int i = 0; i < DEPTH; i++) begin
          scan_idx = head_q + PTR_W'(i);
          if (CNT_W'(i) < count_q) begin
            for (int j = 0; j < NB; j++) begin
              if ((j < size_bytes(size_q[scan_idx])) &&
                  ((addr_q[scan_idx] + ADDR_WIDTH'(j)) == byte_addr)) begin
                fwd_mask_d[k]         = 1'b1;
                fwd_data_d[8*k +: 8]  = data_q[scan_idx][8*j +: 8];
              end
            end
          end
        end
        if (push_fire) begin
          for (int j = 0; j < NB; j++) begin
            if ((j < size_bytes(lsu_stbuf_push_size)) &&
                ((lsu_stbuf_push_addr + ADDR_WIDTH'(j)) == byte_addr)) begin
              fwd_mask_d[k]        = 1'b1;
              fwd_data_d[8*k +: 8] = lsu_stbuf_push_data[8*j +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else if (load_fire) begin
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`else
  assign fwd_mask_q = '0;
  assign fwd_data_q = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_valid_q <= 1'b0;
      ld_size_q  <= '0;
    end else begin
      ld_valid_q <= load_fire;
      if (load_fire) ld_size_q <= lsu_stbuf_load_size;
    end
  end

  // Merge the forwarded bytes over the TCM return. Bytes at or above the load
  // size, and every byte when no result is due, read as zero.
  always_comb begin
    stbuf_lsu_load_data = '0;
    if (ld_valid_q) begin
      for (int k = 0; k < NB; k++) begin
        if (k < size_bytes(ld_size_q)) begin
          stbuf_lsu_load_data[8*k +: 8] = fwd_mask_q[k] ? fwd_data_q[8*k +: 8]
                                                        : tcm_stbuf_read_data[8*k +: 8];
        end
      end
    end
  end

  assign stbuf_lsu_load_data_valid = ld_valid_q;

endmodule
